// File: rtl/switch_pkg.sv
// Shared switch definitions: port count, port index width and the scheduler FSM states.
package switch_pkg;

    localparam int NUM_PORTS = 4;
    localparam int PORT_W    = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        ACCEPT = 2'd2,
        DONE   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the requester with the smallest (index - pointer) mod NUM_PORTS.
module rr_arbiter
    import switch_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_W-1:0]    ptr_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [PORT_W-1:0]    idx_o,
    output logic                 valid_o
);

    logic [PORT_W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = ptr_i + PORT_W'(k);
            if (req_i[cand]) begin
                idx_o   = cand;
                valid_o = 1'b1;
            end
        end
        if (valid_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/crossbar_scheduler.sv
// Single-iteration iSLIP-style crossbar scheduler: latch VOQ requests, grant per egress,
// accept per ingress, then publish a one-to-one match once per time slot.
module crossbar_scheduler
    import switch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        experimenting,
    input  logic        sched_start,
    input  logic [15:0] voq_req,
    output logic        match_valid,
    output logic [3:0]  match_en,
    output logic [7:0]  match_port,
    output logic        busy,
    output logic        overrun,
    output logic [31:0] slot_count
);

    sched_state_t state_q, state_d;

    logic [15:0]                          req_q, req_d;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  grant_q, grant_d;
    logic [NUM_PORTS-1:0][PORT_W-1:0]     grantIdx_q, grantIdx_d;
    logic [NUM_PORTS-1:0][PORT_W-1:0]     grantPtr_q, grantPtr_d;
    logic [NUM_PORTS-1:0][PORT_W-1:0]     acceptPtr_q, acceptPtr_d;
    logic [3:0]                           matchEn_q, matchEn_d;
    logic [7:0]                           matchPort_q, matchPort_d;
    logic                                 matchValid_q, matchValid_d;
    logic                                 overrun_q, overrun_d;
    logic [31:0]                          slotCount_q, slotCount_d;

    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  gReq, gGnt, aReq, aGnt;
    logic [NUM_PORTS-1:0][PORT_W-1:0]     gIdx, aIdx;
    logic [NUM_PORTS-1:0]                 gVld, aVld;
    logic [NUM_PORTS-1:0]                 egressAccepted;

    // gReq is indexed [egress][ingress]; aReq is indexed [ingress][egress].
    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_grant
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_bits
            assign gReq[j][i] = req_q[NUM_PORTS*i + j];
            assign aReq[i][j] = grant_q[j][i];
        end
        rr_arbiter u_grant_arb (
            .req_i   (gReq[j]),
            .ptr_i   (grantPtr_q[j]),
            .gnt_o   (gGnt[j]),
            .idx_o   (gIdx[j]),
            .valid_o (gVld[j])
        );
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_accept
        rr_arbiter u_accept_arb (
            .req_i   (aReq[i]),
            .ptr_i   (acceptPtr_q[i]),
            .gnt_o   (aGnt[i]),
            .idx_o   (aIdx[i]),
            .valid_o (aVld[i])
        );
    end

    always_comb begin
        egressAccepted = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            egressAccepted = egressAccepted | aGnt[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        grant_d      = grant_q;
        grantIdx_d   = grantIdx_q;
        grantPtr_d   = grantPtr_q;
        acceptPtr_d  = acceptPtr_q;
        matchEn_d    = matchEn_q;
        matchPort_d  = matchPort_q;
        matchValid_d = 1'b0;
        overrun_d    = overrun_q | (sched_start && (state_q != IDLE));
        slotCount_d  = slotCount_q;

        case (state_q)
            IDLE: begin
                if (sched_start && experimenting) begin
                    req_d   = voq_req;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                for (int j = 0; j < NUM_PORTS; j++) begin
                    grant_d[j]    = gVld[j] ? gGnt[j] : '0;
                    grantIdx_d[j] = gIdx[j];
                end
                state_d = ACCEPT;
            end
            ACCEPT: begin
                // Only accepted grants move pointers; a refused grant leaves its egress pointer alone.
                matchEn_d   = '0;
                matchPort_d = '0;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (aVld[i]) begin
                        matchEn_d[i]          = 1'b1;
                        matchPort_d[2*i +: 2] = aIdx[i];
                        acceptPtr_d[i]        = aIdx[i] + 2'd1;
                    end
                end
                for (int j = 0; j < NUM_PORTS; j++) begin
                    if (egressAccepted[j]) begin
                        grantPtr_d[j] = grantIdx_q[j] + 2'd1;
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                matchValid_d = 1'b1;
                slotCount_d  = slotCount_q + 32'd1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            req_q        <= '0;
            grant_q      <= '0;
            grantIdx_q   <= '0;
            grantPtr_q   <= '0;
            acceptPtr_q  <= '0;
            matchEn_q    <= '0;
            matchPort_q  <= '0;
            matchValid_q <= 1'b0;
            overrun_q    <= 1'b0;
            slotCount_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            grant_q      <= grant_d;
            grantIdx_q   <= grantIdx_d;
            grantPtr_q   <= grantPtr_d;
            acceptPtr_q  <= acceptPtr_d;
            matchEn_q    <= matchEn_d;
            matchPort_q  <= matchPort_d;
            matchValid_q <= matchValid_d;
            overrun_q    <= overrun_d;
            slotCount_q  <= slotCount_d;
        end
    end

    assign match_valid = matchValid_q;
    assign match_en    = matchEn_q;
    assign match_port  = matchPort_q;
    assign busy        = (state_q != IDLE);
    assign overrun     = overrun_q;
    assign slot_count  = slotCount_q;

endmodule

// File: tb/tb_crossbar_scheduler.sv
// Directed bench for crossbar_scheduler with hand-computed match results per slot.
module tb_crossbar_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        experimenting = 1'b1;
    logic        sched_start = 1'b0;
    logic [15:0] voq_req = '0;
    logic        match_valid;
    logic [3:0]  match_en;
    logic [7:0]  match_port;
    logic        busy;
    logic        overrun;
    logic [31:0] slot_count;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    crossbar_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .experimenting (experimenting),
        .sched_start   (sched_start),
        .voq_req       (voq_req),
        .match_valid   (match_valid),
        .match_en      (match_en),
        .match_port    (match_port),
        .busy          (busy),
        .overrun       (overrun),
        .slot_count    (slot_count)
    );

    always #5 clk = ~clk;

    // Counts every cycle in which match_valid was high.
    always @(posedge clk) begin
        if (match_valid) pulses <= pulses + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset       = 1'b1;
        sched_start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Start one slot, scramble voq_req right after it is latched, and wait for match_valid.
    task automatic applyStimulus(input logic [15:0] req, input bit dropExp, output int lat);
        @(negedge clk);
        voq_req     = req;
        sched_start = 1'b1;
        @(negedge clk);
        sched_start = 1'b0;
        voq_req     = ~req;
        if (dropExp) experimenting = 1'b0;
        checkOutput("busyMid", 32'(busy), 32'd1);
        lat = 0;
        while (!match_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'd3);
        experimenting = 1'b1;
    endtask

    task automatic checkMatch(input string tag, input logic [3:0] en, input logic [7:0] port, input logic [31:0] cnt);
        checkOutput({tag, "_valid"}, 32'(match_valid), 32'd1);
        checkOutput({tag, "_en"}, 32'(match_en), 32'(en));
        checkOutput({tag, "_port"}, 32'(match_port), 32'(port));
        checkOutput({tag, "_count"}, slot_count, cnt);
    endtask

    initial begin
        int lat;
        int p0;
        logic [31:0] c0;

        // Reset state
        doReset();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_valid", 32'(match_valid), 32'd0);
        checkOutput("rst_en", 32'(match_en), 32'd0);
        checkOutput("rst_port", 32'(match_port), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_count", slot_count, 32'd0);
        reset = 1'b0;

        // Single request ingress 0 -> egress 0
        applyStimulus(16'h0001, 1'b0, lat);
        checkMatch("single", 4'b0001, 8'h00, 32'd1);
        @(negedge clk);
        checkOutput("single_pulseEnd", 32'(match_valid), 32'd0);
        checkOutput("single_busyIdle", 32'(busy), 32'd0);
        checkOutput("single_hold_en", 32'(match_en), 32'd1);

        // All ingresses contend for egress 0: grant rotates
        doReset();
        for (int s = 0; s < 4; s++) begin
            logic [3:0] en;
            en = 4'b0001 << s;
            applyStimulus(16'h1111, 1'b0, lat);
            checkMatch("rotate", en, 8'h00, 32'(s + 1));
        end

        // Full request matrix
        doReset();
        applyStimulus(16'hFFFF, 1'b0, lat);
        checkMatch("full1", 4'b0001, 8'h00, 32'd1);
        applyStimulus(16'hFFFF, 1'b0, lat);
        checkMatch("full2", 4'b0011, 8'h01, 32'd2);
        applyStimulus(16'hFFFF, 1'b0, lat);
        checkMatch("full3", 4'b0111, 8'h06, 32'd3);

        // Empty slot leaves pointers alone
        doReset();
        applyStimulus(16'hFFFF, 1'b0, lat);
        checkMatch("emptyPre", 4'b0001, 8'h00, 32'd1);
        applyStimulus(16'h0000, 1'b0, lat);
        checkMatch("empty", 4'b0000, 8'h00, 32'd2);
        applyStimulus(16'hFFFF, 1'b0, lat);
        checkMatch("emptyPost", 4'b0011, 8'h01, 32'd3);

        // Start while busy
        doReset();
        p0 = pulses;
        @(negedge clk);
        voq_req     = 16'h0001;
        sched_start = 1'b1;
        @(negedge clk);
        sched_start = 1'b1;
        @(negedge clk);
        sched_start = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("ovr_flag", 32'(overrun), 32'd1);
        checkOutput("ovr_count", slot_count, 32'd1);
        checkOutput("ovr_pulses", 32'(pulses - p0), 32'd1);
        checkOutput("ovr_en", 32'(match_en), 32'd1);

        // Reset during ACCEPT aborts the slot
        doReset();
        applyStimulus(16'hFFFF, 1'b0, lat);
        checkMatch("abortPre", 4'b0001, 8'h00, 32'd1);
        @(negedge clk);
        voq_req     = 16'hFFFF;
        sched_start = 1'b1;
        @(negedge clk);
        sched_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        p0 = pulses;
        @(negedge clk);
        checkOutput("abort_valid", 32'(match_valid), 32'd0);
        checkOutput("abort_en", 32'(match_en), 32'd0);
        checkOutput("abort_port", 32'(match_port), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_count", slot_count, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("abort_pulses", 32'(pulses - p0), 32'd0);
        applyStimulus(16'hFFFF, 1'b0, lat);
        checkMatch("abortPost", 4'b0001, 8'h00, 32'd1);

        // experimenting falls mid-slot: slot still completes
        applyStimulus(16'h0010, 1'b1, lat);
        checkMatch("expDrop", 4'b0010, 8'h00, 32'd2);

        // experimenting low in IDLE: start ignored
        @(negedge clk);
        experimenting = 1'b0;
        p0 = pulses;
        c0 = slot_count;
        voq_req     = 16'h0001;
        sched_start = 1'b1;
        @(negedge clk);
        sched_start = 1'b0;
        checkOutput("expOff_busy", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        checkOutput("expOff_pulses", 32'(pulses - p0), 32'd0);
        checkOutput("expOff_count", slot_count, c0);
        experimenting = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crossbar_scheduler.md
CROSSBAR_SCHEDULER -- requirements
Module: crossbar_scheduler

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- experimenting  in  1  scheduler enable (high while the switch is in experiment mode).
- sched_start  in  1  one-cycle pulse marking the start of a time slot.
- voq_req  in  16  VOQ occupancy; bit 4*i+j set = ingress i holds a packet for egress j.
- match_valid  out  1  one-cycle pulse; the match outputs are new this cycle.
- match_en  out  4  bit i set = ingress i is matched this slot.
- match_port  out  8  bits [2i+1:2i] = egress index matched to ingress i; 0 when match_en[i]=0.
- busy  out  1  high whenever the FSM is not in IDLE.
- overrun  out  1  sticky; set when sched_start arrives while busy.
- slot_count  out  32  number of completed slots.

Function
REQ-002 The FSM SHALL have four states: IDLE, GRANT, ACCEPT, DONE.
REQ-003 In IDLE, with sched_start=1 and experimenting=1, the block SHALL latch voq_req and go to GRANT.
REQ-004 In IDLE, sched_start SHALL be ignored while experimenting=0.
REQ-005 GRANT SHALL register, for each egress j, one grant: the requesting ingress i with the smallest (i - grant_ptr[j]) mod 4. It SHALL then go to ACCEPT.
REQ-006 ACCEPT SHALL pick, for each ingress i, among the grants it received, the egress j with the smallest (j - accept_ptr[i]) mod 4.
REQ-007 ACCEPT SHALL register match_en and match_port from those picks, then go to DONE.
REQ-008 For each accepted pair i->j, ACCEPT SHALL set accept_ptr[i]=(j+1) mod 4 and grant_ptr[j]=(i+1) mod 4.
REQ-009 Pointers of grants that are not accepted SHALL NOT change.
REQ-010 DONE SHALL assert match_valid for exactly one cycle, increment slot_count (32-bit, wraps from FFFFFFFF to 0) and return to IDLE.
REQ-011 Latency: if sched_start is sampled at edge k, match_valid SHALL be high in the cycle after edge k+3.
REQ-012 busy SHALL be high in GRANT, ACCEPT and DONE.
REQ-013 A new slot SHALL be accepted in the cycle busy falls.
REQ-014 sched_start while busy SHALL be ignored and SHALL set overrun; overrun is cleared only by reset.
REQ-015 match_en and match_port SHALL hold their values until the next ACCEPT.
REQ-016 The match SHALL be one-to-one: at most one ingress per egress and one egress per ingress.
REQ-017 A slot with no requests SHALL still pulse match_valid, with match_en=0, and pointers unchanged.
REQ-018 Changes on voq_req after latching SHALL NOT affect the slot in progress.
REQ-019 If experimenting falls mid-slot, the slot in progress SHALL complete.

Reset
REQ-020 When reset=1, the FSM SHALL go to IDLE.
REQ-021 When reset=1, all grant_ptr and accept_ptr SHALL become 0.
REQ-022 When reset=1, match_valid, match_en, match_port, busy, overrun and slot_count SHALL become 0.
REQ-023 When reset=1, the latched requests SHALL be cleared.
REQ-024 Reset SHALL take priority over any state, including mid-slot; the aborted slot SHALL produce no match_valid.

Structure
REQ-025 A shared package switch_pkg SHALL define NUM_PORTS=4, PORT_W=2 and the FSM state enum.
REQ-026 The design SHALL use one sub-module, rr_arbiter: 4-bit request + 2-bit pointer in, one-hot grant + 2-bit index + any-valid out.
REQ-027 rr_arbiter SHALL be instantiated 8 times: 4 for grant, 4 for accept.

Verification
REQ-028 The bench SHALL cover these scenarios:
- Reset, voq_req=16'h0001, start -> match_valid at edge k+3 (REQ-011); match_en=4'b0001; match_port=8'h00; slot_count=1.
- voq_req=16'h1111 held for 4 slots -> match_en 0001, 0010, 0100, 1000 in turn; match_port=0 for the matched ingress.
- voq_req=16'hFFFF from reset -> slot 1: match_en=0001, match_port=8'h00. Slot 2: match_en=0011, match_port[1:0]=1, match_port[3:2]=0.
- Start pulsed in GRANT -> ignored; overrun=1; slot_count rises by exactly 1.
- Reset asserted in ACCEPT -> no match_valid; all outputs 0. The next slot with 16'hFFFF repeats the slot-1 result.
- voq_req=0, start -> match_valid pulses; match_en=0; pointers unchanged; slot_count increments. Same with experimenting=0 -> no pulse.
